// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle main control FSM (fetch/decode/execute/memory/writeback sequencing)
//   in : clk, rst_n (async active-low), opcode, funct, zero (ALU Zero), mem_ready
//   out: datapath controls (pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
//        mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op), instr_done/illegal_op pulses,
//        state (debug)
module mc_ctrl_fsm #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic [OP_W-1:0] alu_op,
  output logic            instr_done,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
  } state_t;
  localparam logic [OP_W-1:0] ALU_NOP = OP_W'(6'h00);
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(6'h20);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'(6'h02);
  localparam logic [OP_W-1:0] ALU_AND = OP_W'(6'h03);
  localparam logic [OP_W-1:0] ALU_OR  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] ALU_XOR = OP_W'(6'h05);
  localparam logic [OP_W-1:0] ALU_NOR = OP_W'(6'h06);
  state_t state_q, state_d;
  logic instr_done_q, instr_done_d, illegal_op_q, illegal_op_d;
  logic pc_write, pc_write_cond, r_ok;
  logic [OP_W-1:0] r_op;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_done_q <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
      illegal_op_q <= illegal_op_d;
    end
  end
  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_NOP;
    case (funct)
      6'h20:   r_op = ALU_ADD;
      6'h22:   r_op = ALU_SUB;
      6'h24:   r_op = ALU_AND;
      6'h25:   r_op = ALU_OR;
      6'h26:   r_op = ALU_XOR;
      6'h27:   r_op = ALU_NOR;
      default: r_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d       = state_q;
    instr_done_d  = 1'b0;
    illegal_op_d  = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = ALU_NOP;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          6'h23, 6'h2B: state_d = MEM_ADDR;
          6'h00:        state_d = R_EXEC;
          6'h04:        state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h08:        state_d = I_EXEC;
          default: begin
            state_d      = FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done_d = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        mem_write    = 1'b1;
        iord         = 1'b1;
        instr_done_d = mem_ready;
        state_d      = mem_ready ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        alu_src_a    = 1'b1;
        alu_op       = r_op;
        illegal_op_d = !r_ok;
        state_d      = r_ok ? R_WB : FETCH;
      end
      R_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        instr_done_d = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done_d  = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write     = 1'b1;
        pc_source    = 2'b10;
        instr_done_d = 1'b1;
        state_d      = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write    = 1'b1;
        instr_done_d = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  assign pc_en      = pc_write | (pc_write_cond & zero);
  assign instr_done = instr_done_q;
  assign illegal_op = illegal_op_q;
  assign state      = ST_W'(state_q);
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h20;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic instr_done, illegal_op;
  logic [3:0] state;
  int checks = 0, failures = 0;
  logic [31:0] sb[$];
  bit pd = 0, pi = 0;
  localparam logic [3:0] IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5,
    MEM_WR = 6, R_EXEC = 7, R_WB = 8, BRANCH = 9, JUMP = 10, I_EXEC = 11, I_WB = 12;
  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b, pc_source, alu_op}
  function automatic logic [18:0] outs(input logic [3:0] st, input logic mr, input logic z,
                                       input logic [5:0] fn);
    logic [8:0] b;
    logic [1:0] sb_, ps;
    logic [5:0] op;
    b = '0; sb_ = 2'b00; ps = 2'b00; op = 6'h00;
    case (st)
      FETCH:    begin b = {mr, mr, 1'b0, 1'b1, 5'b0}; sb_ = 2'b01; op = 6'h20; end
      DECODE:   begin sb_ = 2'b11; op = 6'h20; end
      MEM_ADDR: begin b = 9'b000000001; sb_ = 2'b10; op = 6'h20; end
      MEM_RD:   b = 9'b001100000;
      MEM_WB:   b = 9'b000001010;
      MEM_WR:   b = 9'b001010000;
      R_EXEC: begin
        b = 9'b000000001;
        op = fn == 6'h20 ? 6'h20 : fn == 6'h22 ? 6'h02 : fn == 6'h24 ? 6'h03 :
             fn == 6'h25 ? 6'h04 : fn == 6'h26 ? 6'h05 : fn == 6'h27 ? 6'h06 : 6'h00;
      end
      R_WB:     b = 9'b000001100;
      BRANCH:   begin b = {z, 8'b00000001}; ps = 2'b01; op = 6'h02; end
      JUMP:     begin b = 9'b100000000; ps = 2'b10; end
      I_EXEC:   begin b = 9'b000000001; sb_ = 2'b10; op = 6'h20; end
      I_WB:     b = 9'b000001000;
      default:  ;
    endcase
    return {b, sb_, ps, op};
  endfunction
  // One cycle: drive inputs, push the expected vector, sample 1ns later, pop and compare.
  // ret/ill mark that this cycle retires / flags illegal, so the pulse is due next cycle.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input bit ret,
                     input bit ill);
    logic [31:0] got, e;
    mem_ready = mr;
    zero = z;
    sb.push_back({7'b0, st, outs(st, mr, z, funct), pd, pi});
    pd = ret;
    pi = ill;
    #1;
    got = {7'b0, state, pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal_op};
    e = sb.pop_front();
    check($sformatf("st%0d_op%h_fn%h", st, opcode, funct), got, e);
    @(negedge clk);
  endtask
  task automatic rtype(input logic [5:0] fn);
    opcode = 6'h00; funct = fn;
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(R_EXEC, 1, 0, 0, 0);
    cyc(R_WB, 1, 0, 1, 0);
  endtask
  initial begin
    logic [5:0] fl[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    @(negedge clk);
    cyc(IDLE, 1, 0, 0, 0);
    rst_n = 1'b1;
    cyc(IDLE, 1, 0, 0, 0);
    rtype(6'h20);
    opcode = 6'h23;
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(MEM_ADDR, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(MEM_RD, 0, 0, 0, 0);
    cyc(MEM_RD, 1, 0, 0, 0);
    cyc(MEM_WB, 1, 0, 1, 0);
    opcode = 6'h04;
    cyc(FETCH, 1, 1, 0, 0);
    cyc(DECODE, 1, 1, 0, 0);
    cyc(BRANCH, 1, 1, 1, 0);
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(BRANCH, 1, 0, 1, 0);
    opcode = 6'h02;
    cyc(FETCH, 0, 0, 0, 0);
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(JUMP, 1, 0, 1, 0);
    opcode = 6'h08;
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(I_EXEC, 1, 0, 0, 0);
    cyc(I_WB, 1, 0, 1, 0);
    opcode = 6'h3F;
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 1);
    opcode = 6'h00; funct = 6'h03;
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(R_EXEC, 1, 0, 0, 1);
    foreach (fl[i]) rtype(fl[i]);
    opcode = 6'h2B;
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(MEM_ADDR, 1, 0, 0, 0);
    cyc(MEM_WR, 0, 0, 0, 0);
    #1;
    check("sw_wr_before_rst", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("sw_wr_after_rst", 32'(mem_write), 32'd0);
    check("sw_state_after_rst", 32'(state), 32'(IDLE));
    @(negedge clk);
    pd = 0; pi = 0;
    cyc(IDLE, 1, 0, 0, 0);
    rst_n = 1'b1;
    cyc(IDLE, 1, 0, 0, 0);
    cyc(FETCH, 1, 0, 0, 0);
    cyc(DECODE, 1, 0, 0, 0);
    cyc(MEM_ADDR, 1, 0, 0, 0);
    cyc(MEM_WR, 1, 0, 1, 0);
    cyc(FETCH, 1, 0, 0, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle main control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states.
- It is the issuing end of the ALU opcode interface: it drives alu_op into the datapath ALU and consumes the ALU Zero flag for branch resolution.
- It sits between the instruction register/memory handshake and the datapath muxes, register file and PC.

Parameters:
- OP_W, 6, width of the ALU opcode bus.
- ST_W, 4, width of the state register exported for debug.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU Zero flag (ALU result == 0).
- mem_ready  input  1  memory access completes this cycle.
- pc_en  output  1  PC load enable: pc_write OR (pc_write_cond AND zero).
- ir_write  output  1  instruction register load.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback data select: 0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- pc_source  output  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  output  OP_W  ALU opcode.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode or funct.
- state  output  ST_W  current state, for debug.

Behaviour:
- ALU opcode set: NOP 6'h00, ADD 6'h20, SUB 6'h02, AND 6'h03, OR 6'h04, XOR 6'h05, NOR 6'h06. IS_POSIT 6'h3F is never issued.
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - instr_done and illegal_op registers clear to 0.
  - All outputs are 0 and alu_op=NOP while in IDLE.
  - The first rising edge after reset release moves the FSM to FETCH.
- Reset mid-instruction aborts immediately; no write enable may be high once rst_n falls.
- Any output not listed for a state is 0; alu_op is NOP unless listed.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes the branch target).
  - Next state by opcode: 0x23 or 0x2B -> MEM_ADDR; 0x00 -> R_EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> I_EXEC.
  - Any other opcode -> FETCH with illegal_op pulsed.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next: MEM_RD for lw (0x23), MEM_WR for sw (0x2B).
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00.
  - funct map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR; next state R_WB.
  - Unknown funct: alu_op=NOP, illegal_op pulsed, next state FETCH, no register write.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01. pc_en follows zero combinationally. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, ADD. Go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- instr_done: registered pulse, high in the cycle after leaving any of MEM_WB, MEM_WR (with mem_ready), R_WB, BRANCH, JUMP, I_WB.
- illegal_op: registered pulse, high in the cycle after the illegal decision.
- Latency with zero wait states:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Outputs are Moore-decoded from state, except ir_write, pc_en in FETCH (mem_ready) and pc_en in BRANCH (zero).

Test Plan:
- Reset, then release with mem_ready=1, opcode=0x00, funct=0x20:
  - Required: IDLE, FETCH, DECODE, R_EXEC (alu_op=6'h20), R_WB (reg_write=1, reg_dst=1).
  - instr_done=1 one cycle later.
- lw (0x23) with mem_ready held 0 for 3 cycles in MEM_RD:
  - Required: state stays 4 for 3 cycles; mem_read=1 and iord=1 throughout.
  - Then MEM_WB with mem_to_reg=1; 8 cycles FETCH-to-FETCH.
- beq (0x04): zero=1 in BRANCH -> pc_en=1, pc_source=01, alu_op=6'h02. Repeat with zero=0 -> pc_en=0.
- Illegal cases:
  - opcode=0x3F -> DECODE goes to FETCH, illegal_op pulses once, no reg_write/mem_write at any point.
  - opcode=0x00, funct=0x03 -> same result via R_EXEC.
- sw (0x2B) with rst_n dropped while in MEM_WR:
  - Required: mem_write falls immediately and state=IDLE.
  - After release, the FSM restarts in FETCH.
- funct sweep 0x20, 0x22, 0x24, 0x25, 0x26, 0x27 -> alu_op 6'h20, 02, 03, 04, 05, 06 respectively in R_EXEC.
